// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode slice of the vectorized CPU:
// instruction field layout, the HALT opcode, the fetch FSM states and the F/D register record.
package cpu_pkg;

   localparam int unsigned PC_W     = 32;
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 5;
   // The opcode sits in the top bits of the instruction word.
   localparam int unsigned OPCODE_MSB = INSTR_W - 1;

   localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b11111;
   localparam logic [INSTR_W-1:0]  NOP         = '0;

   typedef enum logic {
      RUN,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instruction;
      logic [PC_W-1:0]    pcPlus1;
      logic               valid;
   } fd_reg_t;

endpackage

// File: rtl/pc_register.sv
// Program-counter flop: a branch redirect beats a hold, and a hold beats the +1 increment.
module pc_register #(
   parameter int unsigned           PCWIDTH = 32,
   parameter logic [PCWIDTH-1:0]    RESETPC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               branch,
   input  logic [PCWIDTH-1:0] branch_target,
   input  logic               hold,
   output logic [PCWIDTH-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESETPC;
      end else if (branch) begin
         pc <= branch_target;
      end else if (!hold) begin
         pc <= pc + PCWIDTH'(1);
      end
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage and F/D pipeline register: owns the PC, the HALT freeze FSM
// and the count of valid instructions delivered to decode.
module fetch_decode_stage
   import cpu_pkg::*;
#(
   parameter int unsigned              PCWIDTH     = PC_W,
   parameter int unsigned              INSTRWIDTH  = INSTR_W,
   parameter int unsigned              OPCODEWIDTH = OPCODE_W,
   parameter logic [OPCODEWIDTH-1:0]   HALTOPCODE  = HALT_OPCODE,
   parameter logic [PCWIDTH-1:0]       RESETPC     = '0,
   parameter int unsigned              COUNTWIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stallF,
   input  logic                  stallD,
   input  logic                  flushD,
   input  logic                  takeBranchE,
   input  logic [PCWIDTH-1:0]    branchTargetE,
   input  logic [INSTRWIDTH-1:0] instructionF,
   output logic [PCWIDTH-1:0]    pcF,
   output logic [INSTRWIDTH-1:0] instructionD,
   output logic [PCWIDTH-1:0]    pcPlus1D,
   output logic                  validD,
   output logic                  halted,
   output logic [COUNTWIDTH-1:0] instrCountD
);

   fetch_state_t          state, state_next;
   fd_reg_t               fd;
   logic                  halt_fetch;
   logic                  pc_hold;
   logic [OPCODEWIDTH-1:0] opcode_f;

   assign opcode_f = instructionF[INSTRWIDTH-1 -: OPCODEWIDTH];

   // A HALT word only freezes fetch if it is really being consumed this cycle.
   assign halt_fetch = (state == RUN) && (opcode_f == HALTOPCODE) && !stallF && !takeBranchE;
   assign pc_hold    = stallF || (state == HALT) || halt_fetch;

   pc_register #(
      .PCWIDTH (PCWIDTH),
      .RESETPC (RESETPC)
   ) u_pc_register (
      .clk           (clk),
      .reset         (reset),
      .branch        (takeBranchE),
      .branch_target (branchTargetE),
      .hold          (pc_hold),
      .pc            (pcF)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (halt_fetch)  state_next = HALT;
         HALT:    if (takeBranchE) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Flush and redirect beat stallD; HALT bubbles only when decode is not stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         fd          <= '0;
         instrCountD <= '0;
      end else if (flushD || takeBranchE) begin
         fd <= '{instruction: NOP, pcPlus1: '0, valid: 1'b0};
      end else if (stallD) begin
         fd <= fd;
      end else if (state == HALT) begin
         fd <= '{instruction: NOP, pcPlus1: '0, valid: 1'b0};
      end else begin
         fd          <= '{instruction: instructionF, pcPlus1: pcF + PCWIDTH'(1), valid: 1'b1};
         instrCountD <= instrCountD + COUNTWIDTH'(1);
      end
   end

   assign instructionD = fd.instruction;
   assign pcPlus1D     = fd.pcPlus1;
   assign validD       = fd.valid;
   assign halted       = (state == HALT);

endmodule
